// File: rtl/comparador_pkg.sv
// Shared types and constants for the bit-serial comparator.
// Verdicts are encoded over {x,y}.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    RES  = 2'b10
  } state_t;

  localparam logic [1:0] MAYOR = 2'b10;
  localparam logic [1:0] MENOR = 2'b01;
  localparam logic [1:0] IGUAL = 2'b00;

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/celda_tipica_d_i.sv
// Right-to-left comparator cell: a differing
// bit pair overrides the running verdict.
module celda_tipica_d_i (
  input  logic a,
  input  logic b,
  input  logic x_in,
  input  logic y_in,
  output logic x_out,
  output logic y_out
);

  logic w_diff;

  assign w_diff = a ^ b;
  assign x_out  = w_diff ? (a & ~b) : x_in;
  assign y_out  = w_diff ? (~a & b) : y_in;

endmodule

// File: rtl/comparador_serie_d_i.sv
// Bit-serial magnitude comparator, LSB first,
// valid/ready on both the bit input and the verdict.
module comparador_serie_d_i
  import comparador_pkg::*;
#(
  parameter int N = 3,
  localparam int CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          a_bit,
  input  logic          b_bit,
  output logic          bit_ready,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          a_mayor,
  output logic          a_menor,
  output logic          iguales,
  output logic [CW-1:0] bit_cnt
);

  state_t        r_state;
  state_t        w_nxt;
  logic          r_x;
  logic          r_y;
  logic [CW-1:0] r_cnt;
  logic          w_x;
  logic          w_y;
  logic          w_clr;
  logic          w_acc;
  logic          w_last;

  celda_tipica_d_i u_celda (
    .a     (a_bit),
    .b     (b_bit),
    .x_in  (r_x),
    .y_in  (r_y),
    .x_out (w_x),
    .y_out (w_y)
  );

  assign bit_ready = (r_state == RECV);
  assign res_valid = (r_state == RES);
  assign busy      = (r_state != IDLE);
  assign w_acc     = bit_valid & bit_ready;
  assign w_last    = (r_cnt == CW'(N - 1));

  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt = RECV;
          w_clr = 1'b1;
        end
      end
      RECV: begin
        if (w_acc && w_last) w_nxt = RES;
      end
      RES: begin
        if (res_ready) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_clr) begin
        r_x   <= 1'b0;
        r_y   <= 1'b0;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_x   <= w_x;
        r_y   <= w_y;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign a_mayor = r_x;
  assign a_menor = r_y;
  assign iguales = ~r_x & ~r_y;
  assign bit_cnt = r_cnt;

endmodule
